fpu_add_arbiter: RTL and testbench
==================================

Name: fpu_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one FP32 adder among NUM_REQ requesters.
- Drives the adder's full handshake: start, operand A, operand B, result strobe, output-valid acknowledge.
- Returns each result tagged with the requester ID.
- A watchdog resets a hung adder and returns an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)
- TIMEOUT, 64, maximum cycles in any single adder-wait state before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending; held until its req_ready
- req_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*NUM_REQ  operand B, same packing
- req_ready  out  NUM_REQ  one-hot one-cycle pulse; operands of that requester captured
- resp_valid  out  1  one-cycle pulse, result available
- resp_id  out  ID_W  requester owning the response
- resp_z  out  32  sum, or 0x7FC00000 on error
- resp_err  out  1  timeout abort, qualified by resp_valid
- busy  out  1  high in every state except IDLE
- add_rst  out  1  reset to the adder, one-cycle pulse
- add_start  out  1  adder start pulse
- add_a, add_b  out  32  operands to the adder
- add_a_stb, add_b_stb  out  1  operand strobes
- add_a_ack, add_b_ack  in  1  adder operand acknowledges
- add_z  in  32  adder result
- add_z_stb  in  1  adder result strobe
- add_ack_output  out  1  acknowledge for the result and output-valid phases
- add_output_valid  in  1  adder output-valid phase flag
- add_idle  in  1  adder idle status

Behaviour:
- Reset values: all outputs 0; round-robin pointer = NUM_REQ-1, so requester 0 wins first; timer 0; state IDLE.
- IDLE:
  - If any req_valid is set and add_idle=1, grant the first set bit searching from pointer+1 with wrap-around.
  - In that cycle: pulse req_ready[g], latch req_a, req_b and g, set pointer=g, go to START.
  - If add_idle=0, wait; no grant is made.
- START: assert add_start for exactly 1 cycle, then go to SEND_A.
- SEND_A:
  - Hold add_a_stb=1 with add_a driven.
  - On an edge with add_a_ack=1 and add_a_stb=1: drop the strobe, go to SEND_B.
- SEND_B: same as SEND_A, using the B signals, then go to WAIT_Z.
- WAIT_Z:
  - Hold add_ack_output=1.
  - On an edge with add_z_stb=1: capture add_z, go to WAIT_OV.
- WAIT_OV:
  - Keep add_ack_output=1.
  - On an edge with add_output_valid=1: drop add_ack_output, go to RESPOND.
  - add_ack_output must stay high through the edge where add_output_valid is first sampled high.
- RESPOND:
  - Pulse resp_valid with resp_id=g, resp_z=the captured sum, resp_err=0.
  - Go to IDLE.
  - The next grant waits for add_idle=1 again (the adder reports idle one cycle after it returns).
- Watchdog:
  - Timer clears on every state change; it counts in SEND_A, SEND_B, WAIT_Z and WAIT_OV.
  - If timer reaches TIMEOUT-1: drop all strobes, pulse add_rst, go to ABORT.
  - ABORT (1 cycle): pulse resp_valid with resp_err=1, resp_z=0x7FC00000, resp_id=g, then go to IDLE.
- At most one transaction is in flight.
- req_valid deasserting after grant has no effect on the transaction.
- Non-granted requesters keep req_valid high and are not acknowledged.
- rst during any state: return to IDLE immediately, with no response for the in-flight request.
- add_rst is not asserted by rst; the system reset resets the adder directly.
- Nominal latency, grant to resp_valid: 2 + (adder operand waits) + adder compute + 2 cycles.

Test Plan:
- Single request:
  - Stimulus: req 2 with a=0x3F800000, b=0x40000000, behavioural adder model.
  - Response: req_ready=0100 once, then resp_valid with resp_id=2, resp_z=0x40400000, resp_err=0.
- All four requesters valid after reset:
  - Stimulus: four requests, each 1.0+1.0.
  - Response: grants in order 0,1,2,3; four responses of 0x40000000 with matching IDs; no add_start while add_idle=0.
- Fairness:
  - Stimulus: requester 1 just served; requesters 0 and 1 then both valid.
  - Response: 0 granted next, then 1.
- Cancellation:
  - Stimulus: a=0x3FC00000, b=0xBFC00000.
  - Response: resp_z=0x00000000.
- Hung adder:
  - Stimulus: model never raises add_z_stb.
  - Response: after TIMEOUT cycles in WAIT_Z, add_rst pulses 1 cycle, then resp_valid with resp_err=1, resp_z=0x7FC00000; the next request completes normally.
- Reset mid-transaction:
  - Stimulus: rst asserted during SEND_B.
  - Response: outputs 0 the next cycle, no resp_valid, busy=0, pointer reset so requester 0 wins next.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter that shares one FP32 adder among NUM_REQ requesters.
// It sequences the adder handshake and aborts a hung adder with an error response.
module fpu_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic [31:0]           resp_z,
   output logic                  resp_err,
   output logic                  busy,
   output logic                  add_rst,
   output logic                  add_start,
   output logic [31:0]           add_a,
   output logic [31:0]           add_b,
   output logic                  add_a_stb,
   output logic                  add_b_stb,
   input  logic                  add_a_ack,
   input  logic                  add_b_ack,
   input  logic [31:0]           add_z,
   input  logic                  add_z_stb,
   output logic                  add_ack_output,
   input  logic                  add_output_valid,
   input  logic                  add_idle
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_SEND_A,
      S_SEND_B,
      S_WAIT_Z,
      S_WAIT_OV,
      S_RESPOND,
      S_ABORT
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cur_id;
   logic [31:0]       op_a;
   logic [31:0]       op_b;
   logic [31:0]       sum;
   logic [TW-1:0]     timer;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;
   logic              in_wait;
   logic              adv;
   logic              tmo;

   // Pick the first pending requester after the previous winner, wrapping
   always_comb begin
      int idx;
      logic [ID_W-1:0] cand;
      gnt_found = 1'b0;
      gnt_id    = '0;
      gnt_oh    = '0;
      sel_a     = '0;
      sel_b     = '0;
      idx       = 0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = ID_W'(idx);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == ID_W'(i)) begin
            gnt_oh[i] = gnt_found;
            sel_a     = req_a[32*i +: 32];
            sel_b     = req_b[32*i +: 32];
         end
      end
   end

   // Progress condition of each adder-wait state and the watchdog trip
   always_comb begin
      in_wait = 1'b0;
      adv     = 1'b0;
      unique case (state)
         S_SEND_A: begin
            in_wait = 1'b1;
            adv     = add_a_ack & add_a_stb;
         end
         S_SEND_B: begin
            in_wait = 1'b1;
            adv     = add_b_ack & add_b_stb;
         end
         S_WAIT_Z: begin
            in_wait = 1'b1;
            adv     = add_z_stb;
         end
         S_WAIT_OV: begin
            in_wait = 1'b1;
            adv     = add_output_valid;
         end
         default: begin
            in_wait = 1'b0;
            adv     = 1'b0;
         end
      endcase
      tmo = in_wait && !adv && (timer == TW'(TIMEOUT - 1));
   end

   // Sequencer: every handshake output is a register set on state entry
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         ptr            <= ID_W'(NUM_REQ - 1);
         cur_id         <= '0;
         op_a           <= '0;
         op_b           <= '0;
         sum            <= '0;
         timer          <= '0;
         req_ready      <= '0;
         resp_valid     <= 1'b0;
         resp_id        <= '0;
         resp_z         <= '0;
         resp_err       <= 1'b0;
         busy           <= 1'b0;
         add_rst        <= 1'b0;
         add_start      <= 1'b0;
         add_a          <= '0;
         add_b          <= '0;
         add_a_stb      <= 1'b0;
         add_b_stb      <= 1'b0;
         add_ack_output <= 1'b0;
      end else begin
         req_ready  <= '0;
         add_start  <= 1'b0;
         add_rst    <= 1'b0;
         resp_valid <= 1'b0;
         if (in_wait && !adv && !tmo) timer <= timer + TW'(1);
         else                         timer <= '0;
         if (tmo) begin
            add_a_stb      <= 1'b0;
            add_b_stb      <= 1'b0;
            add_ack_output <= 1'b0;
            add_rst        <= 1'b1;
            state          <= S_ABORT;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (gnt_found && add_idle) begin
                     req_ready <= gnt_oh;
                     op_a      <= sel_a;
                     op_b      <= sel_b;
                     cur_id    <= gnt_id;
                     ptr       <= gnt_id;
                     add_start <= 1'b1;
                     busy      <= 1'b1;
                     state     <= S_START;
                  end
               end
               S_START: begin
                  add_a     <= op_a;
                  add_a_stb <= 1'b1;
                  state     <= S_SEND_A;
               end
               S_SEND_A: begin
                  if (adv) begin
                     add_a_stb <= 1'b0;
                     add_b     <= op_b;
                     add_b_stb <= 1'b1;
                     state     <= S_SEND_B;
                  end
               end
               S_SEND_B: begin
                  if (adv) begin
                     add_b_stb      <= 1'b0;
                     add_ack_output <= 1'b1;
                     state          <= S_WAIT_Z;
                  end
               end
               S_WAIT_Z: begin
                  if (adv) begin
                     sum   <= add_z;
                     state <= S_WAIT_OV;
                  end
               end
               S_WAIT_OV: begin
                  if (adv) begin
                     add_ack_output <= 1'b0;
                     resp_valid     <= 1'b1;
                     resp_id        <= cur_id;
                     resp_z         <= sum;
                     resp_err       <= 1'b0;
                     state          <= S_RESPOND;
                  end
               end
               S_RESPOND: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               S_ABORT: begin
                  resp_valid <= 1'b1;
                  resp_id    <= cur_id;
                  resp_z     <= 32'h7FC0_0000;
                  resp_err   <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter with a behavioural adder model.
// Responses are checked against a queue of expected results.
module tb_fpu_add_arbiter;

   localparam int NR = 4;
   localparam int IW = 2;
   localparam int TO = 64;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [31:0]   z;
      logic          err;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [32*NR-1:0] req_a = '0;
   logic [32*NR-1:0] req_b = '0;
   logic [NR-1:0]   req_ready;
   logic            resp_valid;
   logic [IW-1:0]   resp_id;
   logic [31:0]     resp_z;
   logic            resp_err;
   logic            busy;
   logic            add_rst;
   logic            add_start;
   logic [31:0]     add_a;
   logic [31:0]     add_b;
   logic            add_a_stb;
   logic            add_b_stb;
   logic            add_a_ack = 1'b0;
   logic            add_b_ack = 1'b0;
   logic [31:0]     add_z = '0;
   logic            add_z_stb = 1'b0;
   logic            add_ack_output;
   logic            add_output_valid = 1'b0;
   logic            add_idle = 1'b1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   resp_cnt = 0;
   int   n_push = 0;
   exp_t sb[$];

   int          m_st = 0;
   int          m_cnt = 0;
   logic [31:0] ma = '0;
   logic [31:0] mb = '0;
   logic        hang = 1'b0;

   fpu_add_arbiter #(
      .NUM_REQ(NR),
      .ID_W(IW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_a(req_a),
      .req_b(req_b),
      .req_ready(req_ready),
      .resp_valid(resp_valid),
      .resp_id(resp_id),
      .resp_z(resp_z),
      .resp_err(resp_err),
      .busy(busy),
      .add_rst(add_rst),
      .add_start(add_start),
      .add_a(add_a),
      .add_b(add_b),
      .add_a_stb(add_a_stb),
      .add_b_stb(add_b_stb),
      .add_a_ack(add_a_ack),
      .add_b_ack(add_b_ack),
      .add_z(add_z),
      .add_z_stb(add_z_stb),
      .add_ack_output(add_ack_output),
      .add_output_valid(add_output_valid),
      .add_idle(add_idle)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] f2d(input logic [31:0] f);
      if (f[30:0] == 31'd0) return {f[31], 63'd0};
      return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a,
                                        input logic [31:0] b);
      real         r;
      logic [63:0] d;
      r = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural adder: acks operands, computes after a delay, idles late
   always @(posedge clk) begin
      if (rst || add_rst) begin
         m_st             <= 0;
         m_cnt            <= 0;
         add_idle         <= 1'b1;
         add_a_ack        <= 1'b0;
         add_b_ack        <= 1'b0;
         add_z_stb        <= 1'b0;
         add_output_valid <= 1'b0;
         add_z            <= '0;
      end else begin
         case (m_st)
            0: if (add_start) begin
               add_idle <= 1'b0;
               m_st     <= 1;
            end
            1: if (add_a_stb && !add_a_ack) add_a_ack <= 1'b1;
               else if (add_a_stb && add_a_ack) begin
                  ma        <= add_a;
                  add_a_ack <= 1'b0;
                  m_st      <= 2;
               end
            2: if (add_b_stb && !add_b_ack) add_b_ack <= 1'b1;
               else if (add_b_stb && add_b_ack) begin
                  mb        <= add_b;
                  add_b_ack <= 1'b0;
                  m_cnt     <= 0;
                  m_st      <= 3;
               end
            3: if (!hang) begin
               if (m_cnt == 2) begin
                  add_z     <= fadd(ma, mb);
                  add_z_stb <= 1'b1;
                  m_st      <= 4;
               end else m_cnt <= m_cnt + 1;
            end
            4: if (add_ack_output) begin
               add_z_stb        <= 1'b0;
               add_output_valid <= 1'b1;
               m_st             <= 5;
            end
            5: if (add_ack_output) begin
               add_output_valid <= 1'b0;
               m_st             <= 6;
            end
            6: begin
               add_idle <= 1'b1;
               m_st     <= 0;
            end
            default: m_st <= 0;
         endcase
      end
   end

   // Response scoreboard and start-while-busy monitor
   always @(negedge clk) begin
      exp_t e;
      if (add_start) chk("start_when_idle", 32'(add_idle), 32'd1);
      if (resp_valid) begin
         chk("resp_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_z", resp_z, e.z);
            chk("resp_err", 32'(resp_err), 32'(e.err));
         end
         resp_cnt++;
      end
   end

   task automatic req(input int id, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] z,
                      input logic err);
      exp_t e;
      req_valid[id]       = 1'b1;
      req_a[32*id +: 32]  = a;
      req_b[32*id +: 32]  = b;
      e.id  = IW'(id);
      e.z   = z;
      e.err = err;
      sb.push_back(e);
      n_push++;
   endtask

   task automatic wait_grant(input int id);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("grant_%0d", id), 32'(req_ready), 32'(1) << id);
      chk("busy_at_grant", 32'(busy), 32'd1);
      for (int i = 0; i < NR; i++) if (req_ready[i]) req_valid[i] = 1'b0;
   endtask

   task automatic wait_resp();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("queue_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_add_start", 32'(add_start), 32'd0);
      chk("rst_add_rst", 32'(add_rst), 32'd0);
      chk("rst_add_a_stb", 32'(add_a_stb), 32'd0);
      chk("rst_ack_output", 32'(add_ack_output), 32'd0);

      req(2, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
      wait_grant(2);
      chk("start_pulse", 32'(add_start), 32'd1);
      @(negedge clk);
      chk("ready_one_pulse", 32'(req_ready), 32'd0);
      chk("a_stb", 32'(add_a_stb), 32'd1);
      chk("a_value", add_a, 32'h3F80_0000);
      wait_resp();

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NR; i++)
         req(i, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
      for (int i = 0; i < NR; i++) wait_grant(i);
      wait_resp();

      req(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
      wait_grant(1);
      wait_resp();
      req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
      req(1, 32'h4080_0000, 32'h3F80_0000, 32'h40A0_0000, 1'b0);
      wait_grant(0);
      wait_grant(1);
      wait_resp();

      req(3, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000, 1'b0);
      wait_grant(3);
      wait_resp();

      hang = 1'b1;
      req(0, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
      wait_grant(0);
      n = 0;
      while (!add_ack_output && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (add_ack_output && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("wait_z_cycles", 32'(n), 32'(TO));
      chk("abort_add_rst", 32'(add_rst), 32'd1);
      chk("abort_no_resp_yet", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("add_rst_one_cycle", 32'(add_rst), 32'd0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd1);
      hang = 1'b0;
      req(1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0);
      wait_grant(1);
      wait_resp();

      req(2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
      wait_grant(2);
      n = 0;
      while (!add_b_stb && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reached_send_b", 32'(add_b_stb), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_b_stb", 32'(add_b_stb), 32'd0);
      chk("midrst_ack_output", 32'(add_ack_output), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      rst = 1'b0;
      void'(sb.pop_back());
      n_push--;
      repeat (10) @(negedge clk);
      req(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
      req(3, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
      wait_grant(0);
      wait_grant(3);
      wait_resp();

      chk("resp_total", 32'(resp_cnt), 32'(n_push));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
